instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting between the MMU instruction port and the controlpath. It owns the fetch PC and drives the MMU instruction address. It captures returned words (or segfaults) into a small in-order queue and presents them to the controlpath over a valid/ready handshake. A redirect from the execution side flushes the queue and restarts fetch at a new address.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- RESET_PC, 32'h0, fetch address after reset
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- instr_addr  out  32  fetch address to MMU; always equals the fetch PC register
- instr  in  32  MMU read data for instr_addr; valid in any cycle where wait_instr=0
- wait_instr  in  1  MMU not ready; instr/instr_segv ignored this cycle
- instr_segv  in  1  instr_addr faulted; qualified by wait_instr=0
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- instruction  out  32  head-of-queue instruction word
- instr_pc  out  32  address of the head entry
- instr_fault  out  1  head entry is a segfault marker
- instr_valid  out  1  head entry present
- instr_ready  in  1  controlpath accepts the head entry this cycle

## Operation
- State: fpc (32 b), FIFO of {pc, instr, fault}, count, mode ∈ {FETCH, HALT}.
- pop = instr_valid & instr_ready.
- push = mode==FETCH & !wait_instr & !redirect & (count<DEPTH | pop).
- On push:
  - enqueue {fpc, instr, instr_segv}.
  - If instr_segv=0: fpc ← fpc+4, with modulo-2^32 wrap (32'hFFFFFFFC → 0).
  - If instr_segv=1: fpc holds and mode ← HALT. The fault entry carries instr=0.
- HALT:
  - No pushes. instr_addr holds the faulting address.
  - Queued entries still drain, the fault marker last.
  - Only redirect or rst leaves HALT.
- redirect has priority over everything:
  - count ← 0 (a same-cycle pop is discarded).
  - Any same-cycle MMU return is dropped.
  - fpc ← {redirect_pc[31:2], 2'b00}; mode ← FETCH.
- Full with simultaneous pop: push allowed, count unchanged.
- Outputs while instr_valid=0: instruction, instr_pc and instr_fault are driven to 0.
- Reset values:
  - fpc=instr_addr=RESET_PC.
  - count=0, mode=FETCH.
  - instr_valid=0, instruction=0, instr_pc=0, instr_fault=0.

## Timing
- Fetch-to-output latency: 1 cycle. A word accepted at edge N is visible on the outputs after edge N (next cycle).
- Peak throughput: 1 instruction/cycle while wait_instr=0 and the consumer is ready.
- Outputs come from registers/FIFO head only. instr_ready affects only the push enable; no combinational path from instr_ready to the outputs, except under FETCH_BYPASS_EN.
- rst asserted mid-operation: next cycle is in the reset state; queue contents are lost.
- rst and redirect together: rst wins.

## Configuration
- FETCH_BYPASS_EN defined:
  - Condition: count==0, mode==FETCH, !wait_instr, !redirect.
  - Outputs show {fpc, instr, instr_segv} combinationally, with instr_valid=1, in the same cycle.
  - If instr_ready=1: the word is consumed without being enqueued (fpc and mode still update as for a push). Latency is 0.
- Undefined: no bypass; minimum latency is 1 cycle, as above.

## Structure
- Shared package rapids_pkg holds:
  - word_t (32 b).
  - fetch_entry_t struct {pc, instr, fault}.
  - INSTR_BYTES=4.
  - fetch_mode_t enum {FETCH, HALT}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty. Simultaneous push+pop on full is legal.
- instr_fetch holds fpc, mode, push/redirect logic and the bypass mux.

## Test plan
- Reset, RESET_PC=0, wait_instr=0, MMU returns addr^32'hA5A5_0000, ready=1 → instr_pc 0,4,8,… on consecutive cycles, first valid one cycle after reset release.
- ready=0 for 10 cycles → exactly 4 entries (pc 0–C) held, instr_addr stuck at 0x10; ready=1 → drains 0,4,8,C then continues at 0x10 with no gap or duplicate.
- wait_instr=1 for 3 cycles at fpc=0x8 → no enqueue, instr_addr stays 0x8; fetch resumes at 0x8.
- instr_segv at 0xC → entry {pc=0xC, fault=1, instr=0} delivered last, no further fetch; redirect_pc=0x103 → queue flushed, next instr_pc=0x100.
- Queue full with redirect and pop in the same cycle → instr_valid=0 next cycle, instr_addr=redirect_pc&~3, popped entry not re-presented.
- RESET_PC=32'hFFFFFFF8 → instr_pc sequence FFFFFFF8, FFFFFFFC, 00000000.

Source files
------------

// File: rtl/rapids_pkg.sv
// Shared types for the fetch path.
//   word_t         : 32-bit machine word
//   fetch_entry_t  : one fetched slot {pc, instr, fault}
//   fetch_mode_t   : fetch engine mode {FETCH, HALT}
//   INSTR_BYTES    : PC increment per fetched word
package rapids_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  fault;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_mode_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous in-order queue of fetch_entry_t.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wr_data : enqueue request and entry
//   pop           : dequeue head (ignored when empty)
//   flush         : drop all entries (wins over push/pop)
//   rd_data       : head entry (undefined contents when empty)
//   count         : number of entries held, 0..DEPTH
//   full, empty   : occupancy flags
// Push on full is accepted only together with a pop.
module fetch_fifo
    import rapids_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage has no reset; stale slots are never visible because count gates them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, drives the MMU instruction port and
// queues returned words (or fault markers) for the controlpath.
// Optional feature macro: FETCH_BYPASS_EN (zero-latency path when queue empty).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   instr_addr                : fetch address to MMU (= fetch PC)
//   instr, wait_instr, instr_segv : MMU return data / stall / fault
//   redirect, redirect_pc     : flush queue and restart fetch
//   instruction, instr_pc, instr_fault, instr_valid : head entry (zero when invalid)
//   instr_ready               : controlpath accepts head entry
module instr_fetch
    import rapids_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr,
    input  logic        wait_instr,
    input  logic        instr_segv,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    output logic        instr_valid,
    input  logic        instr_ready
);

    word_t                  fpc;
    fetch_mode_t            mode;
    fetch_entry_t           new_entry;
    fetch_entry_t           head;
    fetch_entry_t           out_entry;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   bypass;
    logic                   pop;
    logic                   accept;
    logic                   unused_ok;

    assign instr_addr = fpc;

    // A fault slot carries no instruction word.
    assign new_entry = '{pc: fpc, instr: (instr_segv ? 32'h0 : instr), fault: instr_segv};

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty & (mode == FETCH) & ~wait_instr & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_entry   = head;
        instr_valid = ~fifo_empty;
        if (bypass) begin
            out_entry   = new_entry;
            instr_valid = 1'b1;
        end
        instruction = instr_valid ? out_entry.instr : 32'h0;
        instr_pc    = instr_valid ? out_entry.pc    : 32'h0;
        instr_fault = instr_valid ? out_entry.fault : 1'b0;
    end

    assign pop    = instr_valid & instr_ready;
    // A slot frees up this cycle if the head is being consumed.
    assign accept = (mode == FETCH) & ~wait_instr & ~redirect & (~fifo_full | pop);
    // A bypassed word that is consumed immediately never enters the queue.
    assign fifo_push = accept & ~(bypass & instr_ready);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (new_entry),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc  <= RESET_PC;
            mode <= FETCH;
        end else if (redirect) begin
            fpc  <= {redirect_pc[31:2], 2'b00};
            mode <= FETCH;
        end else if (accept) begin
            // On a fault the PC stays on the faulting address until redirected.
            if (instr_segv) mode <= HALT;
            else            fpc  <= fpc + 32'(INSTR_BYTES);
        end
    end

    assign unused_ok = ^{redirect_pc[1:0], fifo_count};

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import rapids_pkg::*;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wait_instr = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b1;
    logic        segv_en = 1'b0;
    logic [31:0] segv_addr = 32'hC;

    logic [31:0] instr_addr, instr, instruction, instr_pc;
    logic        instr_segv, instr_fault, instr_valid;

    logic [31:0] instr_addr_w, instr_w, instruction_w, instr_pc_w;
    logic        instr_fault_w, instr_valid_w;
    logic        segv_w = 1'b0;

    int checks = 0;
    int failures = 0;

    // MMU model: data is a function of address, fault at a programmable address.
    assign instr      = instr_addr ^ SALT;
    assign instr_segv = segv_en && (instr_addr == segv_addr);
    assign instr_w    = instr_addr_w ^ SALT;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
        .wait_instr(wait_instr), .instr_segv(instr_segv), .redirect(redirect),
        .redirect_pc(redirect_pc), .instruction(instruction), .instr_pc(instr_pc),
        .instr_fault(instr_fault), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    instr_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .instr_addr(instr_addr_w), .instr(instr_w),
        .wait_instr(wait_instr), .instr_segv(segv_w), .redirect(redirect),
        .redirect_pc(redirect_pc), .instruction(instruction_w), .instr_pc(instr_pc_w),
        .instr_fault(instr_fault_w), .instr_valid(instr_valid_w), .instr_ready(instr_ready)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic fault);
        check({tag, ".valid"}, 32'(instr_valid), 32'h1);
        check({tag, ".pc"}, instr_pc, pc);
        check({tag, ".instr"}, instruction, fault ? 32'h0 : (pc ^ SALT));
        check({tag, ".fault"}, 32'(instr_fault), 32'(fault));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(instr_valid), 32'h0);
        check({tag, ".instr"}, instruction, 32'h0);
        check({tag, ".pc"}, instr_pc, 32'h0);
        check({tag, ".fault"}, 32'(instr_fault), 32'h0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check_idle("rst");
        check("rst.addr", instr_addr, 32'h0);
        check("rst.addr_w", instr_addr_w, 32'hFFFF_FFF8);
        check("rst.valid_w", 32'(instr_valid_w), 32'h0);

        // Streaming, one cycle latency, including 32-bit wrap on the second instance
        rst = 1'b0;
        step();
        check_head("s0", 32'h0, 1'b0);
        check("s0.addr", instr_addr, 32'h4);
        check("w0.pc", instr_pc_w, 32'hFFFF_FFF8);
        check("w0.valid", 32'(instr_valid_w), 32'h1);
        step();
        check_head("s1", 32'h4, 1'b0);
        check("w1.pc", instr_pc_w, 32'hFFFF_FFFC);
        step();
        check_head("s2", 32'h8, 1'b0);
        check("w2.pc", instr_pc_w, 32'h0);
        check("w2.instr", instruction_w, SALT);

        // Backpressure: fill to 4 entries, fetch stalls at 0x10
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        check_idle("bp.flush");
        redirect = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_head("bp.full", 32'h0, 1'b0);
        check("bp.addr", instr_addr, 32'h10);
        instr_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_head("bp.drain", 32'(4 * k), 1'b0);
        end

        // MMU wait at 0x8
        redirect = 1'b1; redirect_pc = 32'h8;
        step();
        check_idle("wt.flush");
        check("wt.addr0", instr_addr, 32'h8);
        redirect = 1'b0; wait_instr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wt.valid", 32'(instr_valid), 32'h0);
            check("wt.addr", instr_addr, 32'h8);
        end
        wait_instr = 1'b0;
        step();
        check_head("wt.r0", 32'h8, 1'b0);
        check("wt.addr1", instr_addr, 32'hC);
        step();
        check_head("wt.r1", 32'hC, 1'b0);

        // Fault at 0xC: marker drains last, fetch halts until redirect
        redirect = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0; segv_en = 1'b1;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("sv.addr", instr_addr, 32'hC);
        check_head("sv.h0", 32'h0, 1'b0);
        instr_ready = 1'b1;
        step(); check_head("sv.h1", 32'h4, 1'b0);
        step(); check_head("sv.h2", 32'h8, 1'b0);
        step(); check_head("sv.h3", 32'hC, 1'b1);
        step(); check_idle("sv.done");
        step(); check_idle("sv.halt");
        check("sv.halt_addr", instr_addr, 32'hC);
        segv_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
        step();
        check_idle("sv.redir");
        check("sv.redir_addr", instr_addr, 32'h100);
        redirect = 1'b0;
        step();
        check_head("sv.new", 32'h100, 1'b0);

        // Full queue, redirect and pop in the same cycle
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_head("fr.full", 32'h100, 1'b0);
        check("fr.addr", instr_addr, 32'h110);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0002_0006;
        step();
        check_idle("fr.flush");
        check("fr.addr2", instr_addr, 32'h0002_0004);
        redirect = 1'b0;
        step();
        check_head("fr.new", 32'h0002_0004, 1'b0);

        // Reset mid-stream, together with redirect
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        check_idle("mr");
        check("mr.addr", instr_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
